// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock ratio measurement path.
// Holds the measurement FSM state type, the default counter width and
// the minimum number of synchronizer stages allowed for sig_in.
package clk_meas_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

    localparam int CNT_W_DEFAULT   = 16;
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk_in domain and flags its
// edges. A chain of SYNC_STAGES flops resolves metastability; one extra
// flop holds the previous synchronized level for edge detection.
// Ports:
//   clk_in  - sampling clock
//   rst     - asynchronous active-high reset
//   sig_in  - asynchronous input level
//   rise    - high for one cycle after a synchronized 0->1 transition
//   fall    - high for one cycle after a synchronized 1->0 transition
module sync_edge_detect
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    // Fewer than two stages is not a safe synchronizer, so clamp upward.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain and previous-level register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], sig_in};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the period and high time of a slow periodic signal in clk_in
// cycles, derives the equivalent divider toggle count and a 50% duty flag,
// and tracks lock (repeated equal periods) and timeout (no rising edge).
// Ports:
//   clk_in, rst  - clock and asynchronous active-high reset
//   sig_in       - asynchronous signal under measurement
//   period       - cycles between the last two rising edges
//   high_time    - cycles from rising edge to following falling edge
//   div_factor   - period >> 1
//   duty_ok      - 2*high_time == period
//   meas_valid   - one-cycle pulse when the measurement outputs update
//   locked       - LOCK_COUNT consecutive equal periods seen
//   timeout      - sticky, no rising edge within 2^CNT_W-1 cycles
module clock_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-2:0] div_factor,
    output logic             duty_ok,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int               MATCH_W = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE = {{(MATCH_W-1){1'b0}}, 1'b1};

    logic               rise_s;
    logic               fall_s;
    meas_state_t        state_r;
    meas_state_t        state_nxt_s;
    logic [CNT_W-1:0]   run_cnt_r;
    logic [CNT_W-1:0]   hi_cap_r;
    logic [MATCH_W-1:0] match_cnt_r;
    logic [MATCH_W-1:0] match_inc_s;
    logic               meas_take_s;
    logic               hi_take_s;
    logic               timeout_hit_s;

    logic [CNT_W-1:0]   period_r;
    logic [CNT_W-1:0]   high_time_r;
    logic [CNT_W-2:0]   div_factor_r;
    logic               duty_ok_r;
    logic               meas_valid_r;
    logic               locked_r;
    logic               timeout_r;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // FSM state register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and per-cycle control decisions; rise beats saturation
    always_comb begin
        state_nxt_s   = state_r;
        meas_take_s   = 1'b0;
        hi_take_s     = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    meas_take_s = 1'b1;
                end else if (run_cnt_r == CNT_MAX) begin
                    timeout_hit_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else if (fall_s) begin
                    hi_take_s = 1'b1;
                end else begin
                    state_nxt_s = MEASURE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Saturating increment of the equal-period counter
    always_comb begin
        match_inc_s = match_cnt_r;
        if (match_cnt_r == MATCH_MAX) begin
            match_inc_s = MATCH_MAX;
        end else begin
            match_inc_s = match_cnt_r + MATCH_ONE;
        end
    end

    // Free-running cycle counter, restarted at 1 on every rising edge
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            run_cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            run_cnt_r <= CNT_ONE;
        end else if (run_cnt_r != CNT_MAX) begin
            run_cnt_r <= run_cnt_r + CNT_ONE;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // High-time capture on falling edges while measuring
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hi_cap_r <= {CNT_W{1'b0}};
        end else if (hi_take_s) begin
            hi_cap_r <= run_cnt_r;
        end else begin
            hi_cap_r <= hi_cap_r;
        end
    end

    // Measurement outputs, lock tracking and sticky timeout
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_r     <= {CNT_W{1'b0}};
            high_time_r  <= {CNT_W{1'b0}};
            div_factor_r <= {(CNT_W-1){1'b0}};
            duty_ok_r    <= 1'b0;
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            timeout_r    <= 1'b0;
            match_cnt_r  <= {MATCH_W{1'b0}};
        end else begin
            meas_valid_r <= meas_take_s;
            if (meas_take_s) begin
                period_r     <= run_cnt_r;
                high_time_r  <= hi_cap_r;
                div_factor_r <= run_cnt_r[CNT_W-1:1];
                // Widened by one bit so doubling high time cannot overflow
                duty_ok_r    <= ({hi_cap_r, 1'b0} == {1'b0, run_cnt_r});
                timeout_r    <= 1'b0;
                if (run_cnt_r == period_r) begin
                    match_cnt_r <= match_inc_s;
                    locked_r    <= (match_inc_s == MATCH_MAX);
                end else begin
                    match_cnt_r <= {MATCH_W{1'b0}};
                    locked_r    <= 1'b0;
                end
            end else if (timeout_hit_s) begin
                timeout_r   <= 1'b1;
                locked_r    <= 1'b0;
                match_cnt_r <= {MATCH_W{1'b0}};
            end else begin
                timeout_r   <= timeout_r;
                locked_r    <= locked_r;
                match_cnt_r <= match_cnt_r;
            end
        end
    end

    assign period     = period_r;
    assign high_time  = high_time_r;
    assign div_factor = div_factor_r;
    assign duty_ok    = duty_ok_r;
    assign meas_valid = meas_valid_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter (CNT_W=8, LOCK_COUNT=4).
// Stimulus is driven one clk_in cycle per step; a reference model pushes
// the expected measurement for every non-arming rising edge and a monitor
// pops and compares whenever meas_valid is seen.
module tb_clock_ratio_meter;

    localparam int CW = 8;
    localparam int LC = 4;

    typedef struct packed {
        logic [CW-1:0] per;
        logic [CW-1:0] hi;
        logic [CW-2:0] div;
        logic          duty;
        logic          lck;
        logic          tmo;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          sig_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic [CW-2:0] div_factor;
    logic          duty_ok;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // reference model state
    int   cyc;
    logic m_lvl;
    logic m_armed;
    int   m_rise;
    int   m_hi;
    int   m_prev_p;
    int   m_match;
    logic m_locked;
    logic m_tmo;

    clock_ratio_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (2),
        .LOCK_COUNT  (LC)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .div_factor (div_factor),
        .duty_ok    (duty_ok),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_lvl    = 1'b0;
        m_armed  = 1'b0;
        m_rise   = 0;
        m_hi     = 0;
        m_prev_p = 0;
        m_match  = 0;
        m_locked = 1'b0;
        m_tmo    = 1'b0;
        sb_q.delete();
    endtask

    // drive one cycle of sig_in and advance the reference model
    task automatic step(input logic v);
        int   p;
        exp_t e;
        @(negedge clk_in);
        sig_in = v;
        cyc++;
        if (v && !m_lvl) begin
            if (m_armed) begin
                p = cyc - m_rise;
                if (p == m_prev_p) begin
                    if (m_match < LC - 1) m_match++;
                    m_locked = (m_match == LC - 1);
                end else begin
                    m_match  = 0;
                    m_locked = 1'b0;
                end
                m_prev_p = p;
                m_tmo    = 1'b0;
                e.per  = CW'(p);
                e.hi   = CW'(m_hi);
                e.div  = (CW-1)'(p >> 1);
                e.duty = ((2 * m_hi) == p);
                e.lck  = m_locked;
                e.tmo  = m_tmo;
                sb_q.push_back(e);
            end
            m_armed = 1'b1;
            m_rise  = cyc;
        end else begin
            if (!v && m_lvl && m_armed) m_hi = cyc - m_rise;
            if (m_armed && (cyc - m_rise) == (2**CW - 1)) begin
                m_tmo    = 1'b1;
                m_locked = 1'b0;
                m_match  = 0;
                m_armed  = 1'b0;
            end
        end
        m_lvl = v;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) step(1'b1);
            for (int i = 0; i < l; i++) step(1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_period"}, period, 0);
        check_val({tag, "_high"}, high_time, 0);
        check_val({tag, "_div"}, div_factor, 0);
        check_val({tag, "_duty"}, duty_ok, 0);
        check_val({tag, "_valid"}, meas_valid, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_timeout"}, timeout, 0);
    endtask

    // scoreboard: compare every measurement pulse against the queue head
    always @(negedge clk_in) begin
        if (!rst && meas_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_meas_valid", meas_valid, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("period", period, mon_e.per);
                check_val("high_time", high_time, mon_e.hi);
                check_val("div_factor", div_factor, mon_e.div);
                check_val("duty_ok", duty_ok, mon_e.duty);
                check_val("locked", locked, mon_e.lck);
                check_val("timeout", timeout, mon_e.tmo);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);

        // divide by 2, lock after 4 measurements
        wave(2, 2, 6);
        check_val("div2_locked", locked, m_locked);
        // divide by 5, then switch to 3 at a rising edge
        wave(5, 5, 6);
        check_val("div5_locked", locked, m_locked);
        wave(3, 3, 6);
        // asymmetric duty
        wave(3, 5, 3);
        // minimum period
        wave(1, 1, 4);
        // rise coinciding with counter saturation: period 255
        wave(1, 254, 1);
        step(1'b1);
        // hold high: timeout after 255 cycles
        for (int i = 0; i < 239; i++) step(1'b1);
        check_val("pre_timeout", timeout, 0);
        for (int i = 0; i < 40; i++) step(1'b1);
        check_val("timeout_set", timeout, m_tmo);
        check_val("timeout_locked", locked, 0);
        check_val("timeout_period_hold", period, m_prev_p);
        // fall while idle is ignored; first rise only arms
        for (int i = 0; i < 3; i++) step(1'b0);
        wave(2, 2, 3);
        check_val("timeout_cleared", timeout, m_tmo);

        // lock again, then reset mid-period
        wave(5, 5, 6);
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        check_val("pre_rst_locked", locked, m_locked);
        @(negedge clk_in);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0);
        wave(2, 2, 3);
        for (int i = 0; i < 10; i++) step(1'b0);
        check_val("sb_drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
